// File: rtl/message_fifo_arbiter.sv
// message_fifo_arbiter: round-robin frame arbiter sharing one message_fifo write port.
// Optional BODY idle timeout is built in when MSG_ARB_TIMEOUT_EN is defined.
module message_fifo_arbiter #(
  parameter int               N_REQ      = 4,
  parameter logic [7:0]       EVENT_BASE = 8'h10,
  parameter logic [N_REQ-1:0] LEN_MASK   = {N_REQ{1'b1}},
  parameter int               GAP_CYCLES = 2,
  parameter int               TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_frame_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_data_latch_i,
  output logic [N_REQ-1:0]   req_grant_o,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   req_abort_o,
  output logic [7:0]         seq_num_o,
  output logic [7:0]         fifo_in_data_o,
  output logic               fifo_in_data_latch_o,
  output logic               fifo_in_frame_valid_o,
  input  logic               fifo_in_overflow_i,
  output logic               fifo_populate_len_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SOF   = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [7:0]    seq_q, seq_d;
  logic [1:0]    hcnt_q, hcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          len_q, len_d;

  logic          cur_vld;
  logic          cur_lat;
  logic [7:0]    cur_data;
  logic          ovf_hit;
  logic          to_hit;
  logic          abort_hit;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   pick_j;

  assign cur_vld  = req_frame_valid_i[idx_q];
  assign cur_lat  = req_data_latch_i[idx_q];
  assign cur_data = req_data_i[{idx_q, 3'b000} +: 8];

  assign ovf_hit = fifo_in_overflow_i &
                   ((state_q == S_HDR) | (state_q == S_BODY));
  assign abort_hit = ovf_hit | to_hit;
  assign seq_num_o = seq_q;

`ifdef MSG_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] to_q, to_d;

  // Idle-cycle run length inside BODY; any strobe restarts it.
  always_comb begin
    to_d = '0;
    if (state_q == S_BODY && !cur_lat) begin
      to_d = to_q + 1'b1;
    end
  end

  assign to_hit = (state_q == S_BODY) & cur_vld & ~cur_lat &
                  (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign to_hit = 1'b0;
`endif

  // Round-robin search starting at rr_q.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_j   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_j = {1'b0, rr_q} + (IW+1)'(k);
      if (pick_j >= (IW+1)'(N_REQ)) begin
        pick_j = pick_j - (IW+1)'(N_REQ);
      end
      if (!pick_vld && req_frame_valid_i[pick_j[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pick_j[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    seq_d   = seq_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_SOF;
          idx_d   = pick_idx;
          rr_d    = (pick_idx == IW'(N_REQ - 1)) ?
                    '0 : pick_idx + 1'b1;
        end
      end
      S_SOF: begin
        state_d = S_HDR;
        hcnt_d  = '0;
      end
      S_HDR: begin
        if (ovf_hit) begin
          state_d = S_DRAIN;
        end else if (hcnt_q == 2'd2) begin
          state_d = cur_vld ? S_BODY : S_END;
        end else begin
          hcnt_d = hcnt_q + 2'd1;
        end
      end
      S_BODY: begin
        if (abort_hit) begin
          state_d = S_DRAIN;
        end else if (!cur_vld) begin
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_GAP;
        seq_d   = seq_q + 8'd1;
        len_d   = LEN_MASK[idx_q];
        gcnt_d  = '0;
      end
      S_DRAIN: begin
        if (!cur_vld) begin
          state_d = S_GAP;
          len_d   = 1'b0;
          gcnt_d  = '0;
        end
      end
      S_GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_grant_o           = '0;
    req_ready_o           = '0;
    req_abort_o           = '0;
    fifo_in_frame_valid_o = 1'b0;
    fifo_in_data_latch_o  = 1'b0;
    fifo_in_data_o        = '0;
    fifo_populate_len_o   = 1'b0;
    if (state_q != S_IDLE) begin
      req_grant_o[idx_q] = 1'b1;
    end
    if (abort_hit) begin
      req_abort_o[idx_q] = 1'b1;
    end
    case (state_q)
      S_SOF: begin
        fifo_in_frame_valid_o = 1'b1;
        fifo_in_data_o = EVENT_BASE + 8'(idx_q);
      end
      S_HDR: begin
        fifo_in_frame_valid_o = 1'b1;
        fifo_in_data_latch_o  = 1'b1;
        fifo_in_data_o = (hcnt_q == 2'd0) ? seq_q : 8'h00;
      end
      S_BODY: begin
        fifo_in_frame_valid_o = 1'b1;
        req_ready_o[idx_q]    = 1'b1;
        fifo_in_data_o        = cur_data;
        fifo_in_data_latch_o  = cur_vld & cur_lat;
      end
      S_GAP: begin
        fifo_populate_len_o = len_q & (gcnt_q < GW'(2));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      seq_q   <= '0;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      seq_q   <= seq_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_message_fifo_arbiter.sv
// tb_message_fifo_arbiter: directed scoreboard bench for message_fifo_arbiter.
// Expected FIFO bytes are queued at stimulus time and popped as the DUT emits them.
module tb_message_fifo_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_frame_valid;
  logic [31:0] req_data;
  logic [3:0]  req_data_latch;
  logic [3:0]  req_grant;
  logic [3:0]  req_ready;
  logic [3:0]  req_abort;
  logic [7:0]  seq_num;
  logic [7:0]  fifo_in_data;
  logic        fifo_in_data_latch;
  logic        fifo_in_frame_valid;
  logic        fifo_in_overflow;
  logic        fifo_populate_len;

  int          n_checks = 0;
  int          n_pass = 0;
  int          pop_cnt = 0;
  logic        prev_fv = 1'b0;
  logic [7:0]  exp_b;
  logic [7:0]  sbq[$];

  message_fifo_arbiter #(
    .N_REQ(4),
    .EVENT_BASE(8'h10),
    .LEN_MASK(4'hB),
    .GAP_CYCLES(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_frame_valid_i(req_frame_valid),
    .req_data_i(req_data),
    .req_data_latch_i(req_data_latch),
    .req_grant_o(req_grant),
    .req_ready_o(req_ready),
    .req_abort_o(req_abort),
    .seq_num_o(seq_num),
    .fifo_in_data_o(fifo_in_data),
    .fifo_in_data_latch_o(fifo_in_data_latch),
    .fifo_in_frame_valid_o(fifo_in_frame_valid),
    .fifo_in_overflow_i(fifo_in_overflow),
    .fifo_populate_len_o(fifo_populate_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input int i, input logic [7:0] s);
    sbq.push_back(8'h10 + 8'(i));
    sbq.push_back(s);
    sbq.push_back(8'h00);
    sbq.push_back(8'h00);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!req_ready[i] && n < 60) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(req_ready[i]), 32'd1);
  endtask

  task automatic wait_any(output int who);
    int n;
    n = 0;
    who = -1;
    while (req_ready == 4'h0 && n < 60) begin
      tick();
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      if (req_ready[k]) who = k;
    end
    check("any_ready_wait", 32'(req_ready != 4'h0), 32'd1);
  endtask

  task automatic strobe(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
    req_data_latch[i] = 1'b1;
    tick();
    req_data_latch[i] = 1'b0;
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  // FIFO-side monitor: the SOF byte is captured on the frame_valid rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_in_frame_valid && (!prev_fv || fifo_in_data_latch)) begin
        check("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_b = sbq.pop_front();
          check("fifo_byte", 32'(fifo_in_data), 32'(exp_b));
        end
      end
      if (fifo_in_data_latch) begin
        check("latch_needs_fv", 32'(fifo_in_frame_valid), 32'd1);
      end
      if (fifo_populate_len) pop_cnt++;
    end
    prev_fv <= fifo_in_frame_valid;
  end

  initial begin
    int who;
    int p0;
    logic [7:0] s;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req_frame_valid = '0;
    req_data = '0;
    req_data_latch = '0;
    fifo_in_overflow = 1'b0;
    repeat (3) tick();
    check("rst_grant", 32'(req_grant), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_abort", 32'(req_abort), 32'h0);
    check("rst_seq", 32'(seq_num), 32'h0);
    check("rst_fv", 32'(fifo_in_frame_valid), 32'h0);
    check("rst_latch", 32'(fifo_in_data_latch), 32'h0);
    check("rst_data", 32'(fifo_in_data), 32'h0);
    check("rst_poplen", 32'(fifo_populate_len), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: req0, bytes AA BB CC
    p0 = pop_cnt;
    push_hdr(0, 8'h00);
    sbq.push_back(8'hAA);
    sbq.push_back(8'hBB);
    sbq.push_back(8'hCC);
    req_frame_valid[0] = 1'b1;
    wait_ready(0);
    check("t1_grant", 32'(req_grant), 32'h1);
    strobe(0, 8'hAA);
    strobe(0, 8'hBB);
    strobe(0, 8'hCC);
    req_frame_valid[0] = 1'b0;
    settle();
    check("t1_seq", 32'(seq_num), 32'd1);
    check("t1_poplen", 32'(pop_cnt - p0), 32'd2);
    check("t1_drained", 32'(sbq.size()), 32'd0);

    rst_n = 1'b0;
    tick();
    check("rst2_seq", 32'(seq_num), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 2: all four request, 1-byte frames
    p0 = pop_cnt;
    for (int f = 0; f < 5; f++) begin
      push_hdr(order[f], 8'(f));
      sbq.push_back(8'h20 + 8'(order[f]));
    end
    req_data = 32'h23222120;
    req_frame_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_any(who);
      check("t2_order", 32'(who), 32'(order[f]));
      check("t2_onehot", 32'(req_grant), 32'(1) << order[f]);
      if (who >= 0) begin
        strobe(who, 8'h20 + 8'(who));
        req_frame_valid[who] = 1'b0;
      end
      tick();
      if (f == 0) req_frame_valid[0] = 1'b1;
    end
    req_frame_valid = '0;
    settle();
    check("t2_seq", 32'(seq_num), 32'd5);
    check("t2_poplen", 32'(pop_cnt - p0), 32'd8);
    check("t2_drained", 32'(sbq.size()), 32'd0);

    // Test 3: req2 strobes while req1 owns the FIFO
    p0 = pop_cnt;
    push_hdr(1, 8'd5);
    sbq.push_back(8'h31);
    sbq.push_back(8'h32);
    push_hdr(2, 8'd6);
    sbq.push_back(8'h41);
    sbq.push_back(8'h42);
    req_frame_valid = 4'b0110;
    wait_ready(1);
    check("t3_grant1", 32'(req_grant), 32'h2);
    req_data[23:16] = 8'hEE;
    req_data_latch[2] = 1'b1;
    strobe(1, 8'h31);
    req_data[23:16] = 8'hDD;
    req_data_latch[2] = 1'b1;
    strobe(1, 8'h32);
    req_data_latch[2] = 1'b0;
    req_frame_valid[1] = 1'b0;
    wait_ready(2);
    check("t3_grant2", 32'(req_grant), 32'h4);
    strobe(2, 8'h41);
    strobe(2, 8'h42);
    req_frame_valid[2] = 1'b0;
    settle();
    check("t3_seq", 32'(seq_num), 32'd7);
    check("t3_poplen", 32'(pop_cnt - p0), 32'd2);
    check("t3_drained", 32'(sbq.size()), 32'd0);

    // Test 4: overflow in BODY discards the frame
    p0 = pop_cnt;
    push_hdr(0, 8'd7);
    sbq.push_back(8'h51);
    sbq.push_back(8'h52);
    req_frame_valid[0] = 1'b1;
    wait_ready(0);
    strobe(0, 8'h51);
    strobe(0, 8'h52);
    fifo_in_overflow = 1'b1;
    #1;
    check("t4_abort", 32'(req_abort), 32'h1);
    tick();
    fifo_in_overflow = 1'b0;
    #1;
    check("t4_abort_pulse", 32'(req_abort), 32'h0);
    check("t4_fv_low", 32'(fifo_in_frame_valid), 32'h0);
    check("t4_ready_low", 32'(req_ready), 32'h0);
    tick();
    tick();
    check("t4_grant_held", 32'(req_grant), 32'h1);
    req_frame_valid[0] = 1'b0;
    settle();
    check("t4_seq", 32'(seq_num), 32'd7);
    check("t4_poplen", 32'(pop_cnt - p0), 32'd0);
    check("t4_drained", 32'(sbq.size()), 32'd0);
    fifo_in_overflow = 1'b1;
    #1;
    check("t4_idle_ovf", 32'(req_abort), 32'h0);
    fifo_in_overflow = 1'b0;
    tick();

    // Test 5: reset during BODY
    push_hdr(1, 8'd7);
    sbq.push_back(8'h61);
    req_frame_valid[1] = 1'b1;
    wait_ready(1);
    strobe(1, 8'h61);
    req_data_latch[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_fv", 32'(fifo_in_frame_valid), 32'h0);
    check("t5_grant", 32'(req_grant), 32'h0);
    check("t5_ready", 32'(req_ready), 32'h0);
    check("t5_latch", 32'(fifo_in_data_latch), 32'h0);
    check("t5_seq", 32'(seq_num), 32'h0);
    req_data_latch[1] = 1'b0;
    req_frame_valid[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_hdr(1, 8'd0);
    sbq.push_back(8'h62);
    sbq.push_back(8'h63);
    req_frame_valid[1] = 1'b1;
    wait_ready(1);
    strobe(1, 8'h62);
    strobe(1, 8'h63);
    req_frame_valid[1] = 1'b0;
    settle();
    check("t5_seq_after", 32'(seq_num), 32'd1);
    check("t5_drained", 32'(sbq.size()), 32'd0);

    // Test 6: nine idle BODY cycles on req3
    push_hdr(3, 8'd1);
    req_frame_valid[3] = 1'b1;
    wait_ready(3);
    for (int c = 1; c <= 9; c++) begin
`ifdef MSG_ARB_TIMEOUT_EN
      check("t6_abort", 32'(req_abort), (c == 8) ? 32'h8 : 32'h0);
`else
      check("t6_abort", 32'(req_abort), 32'h0);
`endif
      tick();
    end
`ifdef MSG_ARB_TIMEOUT_EN
    check("t6_ready", 32'(req_ready), 32'h0);
    s = 8'd1;
`else
    check("t6_ready", 32'(req_ready), 32'h8);
    sbq.push_back(8'h77);
    strobe(3, 8'h77);
    s = 8'd2;
`endif
    req_frame_valid[3] = 1'b0;
    settle();
    check("t6_seq", 32'(seq_num), 32'(s));
    check("t6_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
